// File: rtl/peripheral_subtractor_pkg.sv
// Shared constants and result layout for the peripheral subtractor.
package peripheral_subtractor_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_FIFO_DEPTH = 4;
    localparam int ERR_COUNT_W        = 8;

    // Result word at the default width; the top builds the same layout at its own DATA_WIDTH.
    typedef struct packed {
        logic [DEFAULT_DATA_WIDTH-1:0] diff;
        logic                          underflow;
        logic                          overflow;
    } result_t;

    function automatic int occupancy_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/peripheral_subtractor_fifo.sv
// Power-of-two output FIFO: pointers wrap naturally, head read combinationally from storage.
module peripheral_subtractor_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     valid,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               do_pop;

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        do_pop  = pop && (count_q != '0);
        if (push) begin
            mem_d[wptr_q] = push_data;
            wptr_d        = wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q   <= '{default: '0};
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign valid = (count_q != '0);
    assign head  = mem_q[rptr_q];
    assign count = count_q;

endmodule

// File: rtl/peripheral_subtractor.sv
// Recovers an operand from a registered sum: diff = sum - operand, with flags and error count.
// Define PERIPHERAL_SUBTRACTOR_SATURATE_EN to clamp out_diff on underflow/overflow.
module peripheral_subtractor
    import peripheral_subtractor_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH:0]    in_sum,
    input  logic [DATA_WIDTH-1:0]  in_operand,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_diff,
    output logic                   out_underflow,
    output logic                   out_overflow,
    output logic [ERR_COUNT_W-1:0] err_count
);

    // Handshake: a beat transfers on a rising edge where valid & ready are both high;
    // the producer holds valid and payload steady until that edge.
    localparam int CNT_W   = occupancy_width(FIFO_DEPTH);
    localparam int ENTRY_W = DATA_WIDTH + 2;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] diff;
        logic                  underflow;
        logic                  overflow;
    } entry_t;

    logic [DATA_WIDTH+1:0]  full;
    entry_t                 res;
    entry_t                 s1_data_q, s1_data_d;
    logic                   s1_valid_q, s1_valid_d;
    logic [ERR_COUNT_W-1:0] err_count_q, err_count_d;
    logic [CNT_W-1:0]       fifo_count;
    logic [CNT_W-1:0]       occupancy;
    logic                   fifo_valid;
    logic [ENTRY_W-1:0]     fifo_head;
    entry_t                 head;
    logic                   accept;

    always_comb begin
        full          = {1'b0, in_sum} - {2'b0, in_operand};
        res.underflow = full[DATA_WIDTH+1];
        res.overflow  = !full[DATA_WIDTH+1] && full[DATA_WIDTH];
        res.diff      = full[DATA_WIDTH-1:0];
`ifdef PERIPHERAL_SUBTRACTOR_SATURATE_EN
        if (res.underflow) begin
            res.diff = '0;
        end else if (res.overflow) begin
            res.diff = '1;
        end
`endif
    end

    // Ready depends only on registered occupancy, so out_ready never reaches in_ready.
    assign occupancy = fifo_count + {{(CNT_W-1){1'b0}}, s1_valid_q};
    assign in_ready  = rst && (occupancy < CNT_W'(FIFO_DEPTH));
    assign accept    = in_valid && in_ready;

    always_comb begin
        s1_valid_d  = accept;
        s1_data_d   = accept ? res : s1_data_q;
        err_count_d = err_count_q;
        if (accept && (res.underflow || res.overflow) && (err_count_q != '1)) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            err_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            err_count_q <= err_count_d;
        end
    end

    peripheral_subtractor_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s1_valid_q),
        .push_data (s1_data_q),
        .pop       (out_ready),
        .valid     (fifo_valid),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign head          = fifo_head;
    assign out_valid     = fifo_valid;
    assign out_diff      = head.diff;
    assign out_underflow = head.underflow;
    assign out_overflow  = head.overflow;
    assign err_count     = err_count_q;

endmodule

// File: tb/tb_peripheral_subtractor.sv
// Directed bench for peripheral_subtractor at DATA_WIDTH=8, FIFO_DEPTH=4.
module tb_peripheral_subtractor;
    import peripheral_subtractor_pkg::*;

`ifdef PERIPHERAL_SUBTRACTOR_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] in_sum;
    logic [7:0] in_operand;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_diff;
    logic       out_underflow;
    logic       out_overflow;
    logic [7:0] err_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [$bits(result_t)-1:0] exp_q[$];

    peripheral_subtractor dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sum        (in_sum),
        .in_operand    (in_operand),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_diff      (out_diff),
        .out_underflow (out_underflow),
        .out_overflow  (out_overflow),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic result_t model(input logic [8:0] s, input logic [7:0] o);
        int      d;
        result_t r;
        d           = int'(s) - int'(o);
        r.underflow = (d < 0);
        r.overflow  = (d > 255);
        r.diff      = d[7:0];
        if (SAT && r.underflow) r.diff = 8'd0;
        if (SAT && r.overflow)  r.diff = 8'd255;
        return r;
    endfunction

    task automatic drive_beat(input logic [8:0] s, input logic [7:0] o);
        int waited;
        waited = 0;
        @(negedge clk);
        in_valid   = 1'b1;
        in_sum     = s;
        in_operand = o;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("accept_timeout", 32'(waited < 20), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [7:0] d, input logic uf, input logic of);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_diff"}, 32'(out_diff), 32'(d));
        check({tag, "_flags"}, 32'({out_underflow, out_overflow}), 32'({uf, of}));
    endtask

    initial begin
        int accepted;
        int sent;
        int got;
        logic acc;
        result_t r;

        rst = 1'b0; in_valid = 1'b0; in_sum = '0; in_operand = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_out_diff", 32'(out_diff), 32'd0);
        rst = 1'b1;
        out_ready = 1'b1;

        // Basic: 300 - 45 = 255, visible after two edges.
        drive_beat(9'd300, 8'd45);
        @(negedge clk);
        check("lat_not_yet", 32'(out_valid), 32'd0);
        @(negedge clk);
        check_head("basic", 8'd255, 1'b0, 1'b0);
        check("basic_err", 32'(err_count), 32'd0);

        drive_beat(9'd10, 8'd20);
        repeat (2) @(negedge clk);
        check_head("underflow", SAT ? 8'd0 : 8'd246, 1'b1, 1'b0);
        check("underflow_err", 32'(err_count), 32'd1);

        drive_beat(9'd511, 8'd0);
        repeat (2) @(negedge clk);
        check_head("overflow511", 8'd255, 1'b0, 1'b1);
        check("overflow511_err", 32'(err_count), 32'd2);

        drive_beat(9'd400, 8'd100);
        repeat (2) @(negedge clk);
        check_head("overflow400", SAT ? 8'd255 : 8'd44, 1'b0, 1'b1);
        check("overflow400_err", 32'(err_count), 32'd3);

        // Backpressure: consumer stalled, only FIFO_DEPTH beats fit.
        @(negedge clk);
        out_ready = 1'b0;
        accepted  = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            in_valid   = 1'b1;
            in_sum     = 9'(accepted + 100);
            in_operand = 8'(accepted);
            acc        = in_ready;
            @(posedge clk);
            if (acc) accepted++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_accepted", 32'(accepted), 32'd4);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check_head("bp_head", 8'd100, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check_head("bp_stable", 8'd100, 1'b0, 1'b0);
        out_ready = 1'b1;
        check("bp_ready_same_cycle", 32'(in_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check_head("bp_drain", 8'd100, 1'b0, 1'b0);
            @(negedge clk);
            if (i == 0) check("bp_ready_after_pop", 32'(in_ready), 32'd1);
        end
        check("bp_empty", 32'(out_valid), 32'd0);

        // Full-rate streaming with scoreboard.
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (out_valid) begin
                if (exp_q.size() > 0) begin
                    check("stream_data", 32'({out_diff, out_underflow, out_overflow}), 32'(exp_q.pop_front()));
                end else begin
                    check("stream_unexpected", 32'(out_valid), 32'd0);
                end
                got++;
            end else if (sent >= 2 && got < 16) begin
                check("stream_bubble", 32'(out_valid), 32'd1);
            end
            if (sent < 16) begin
                check("stream_in_ready", 32'(in_ready), 32'd1);
                in_valid   = 1'b1;
                in_sum     = 9'($urandom_range(511, 0));
                in_operand = 8'($urandom_range(255, 0));
            end else begin
                in_valid = 1'b0;
            end
            acc = in_valid && in_ready;
            r   = model(in_sum, in_operand);
            @(posedge clk);
            if (acc) begin
                exp_q.push_back(r);
                sent++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("stream_got", 32'(got), 32'd16);
        check("stream_queue_empty", 32'(exp_q.size()), 32'd0);

        // Saturating error counter.
        sent = 0;
        for (int cyc = 0; cyc < 400 && sent < 300; cyc++) begin
            @(negedge clk);
            in_valid   = 1'b1;
            in_sum     = 9'd0;
            in_operand = 8'd1;
            acc        = in_ready;
            @(posedge clk);
            if (acc) sent++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("sat_sent", 32'(sent), 32'd300);
        repeat (4) @(negedge clk);
        check("sat_err_count", 32'(err_count), 32'd255);

        // Reset with two entries buffered.
        out_ready = 1'b0;
        drive_beat(9'd7, 8'd1);
        drive_beat(9'd8, 8'd2);
        repeat (2) @(negedge clk);
        check_head("pre_reset", 8'd6, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_err_count", 32'(err_count), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_no_output", 32'(out_valid), 32'd0);
        drive_beat(9'd5, 8'd3);
        repeat (2) @(negedge clk);
        check_head("post_rst_beat", 8'd2, 1'b0, 1'b0);
        check("post_rst_err", 32'(err_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/peripheral_subtractor.md
Name: peripheral_subtractor

Overview:
- Inverse companion of the registered adder peripheral: takes a (DATA_WIDTH+1)-bit sum and one DATA_WIDTH-bit operand, and recovers the other operand as diff = sum - operand.
- Valid/ready streaming block: one compute register feeding a small output FIFO, so the downstream consumer may stall.
- Flags underflow and overflow, and keeps a saturating error counter for the core's status register.

Parameters:
- DATA_WIDTH, 8, operand/result width; the sum input is DATA_WIDTH+1 bits.
- FIFO_DEPTH, 4, output FIFO entries; a power of two, minimum 2.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  reset, asynchronous, active-low (rst=0 resets).
- in_valid  input  1  input beat present.
- in_ready  output  1  block can accept a beat this cycle.
- in_sum  input  DATA_WIDTH+1  minuend.
- in_operand  input  DATA_WIDTH  subtrahend.
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  consumer takes the head this cycle.
- out_diff  output  DATA_WIDTH  result.
- out_underflow  output  1  in_sum < in_operand for this result.
- out_overflow  output  1  in_sum - in_operand > 2^DATA_WIDTH-1 for this result.
- err_count  output  8  saturating count of results with either flag set.

Behaviour:
- Reset (rst=0, async): compute register invalid; FIFO empty (pointers and count = 0); err_count=0; out_valid=0; out_diff/flags=0; in_ready=0 while rst=0.
- Transfers:
  - Input accept when in_valid & in_ready at a rising edge.
  - Output pop when out_valid & out_ready.
- Arithmetic: full = {1'b0,in_sum} - {2'b0,in_operand}, computed at DATA_WIDTH+2 bits.
  - Underflow = sign bit of full.
  - Overflow = !underflow & full[DATA_WIDTH].
  - The two flags are mutually exclusive.
  - out_diff = full[DATA_WIDTH-1:0] (wrap) unless the optional feature is enabled.
- Stage 1: an accepted beat is registered with result and flags; s1_valid=1 after the edge.
- Stage 2: when s1_valid=1, the entry is written into the FIFO on the next edge and s1_valid clears, unless a new beat is accepted in the same cycle, in which case it reloads.
- Latency: accept at edge N -> out_valid=1 after edge N+1, when the FIFO was empty. Throughput is 1 beat/cycle with out_ready=1.
- in_ready = (fifo_count + s1_valid) < FIFO_DEPTH, from registered state only; no combinational path from out_ready to in_ready.
  - A pop in the same cycle does not raise in_ready until the next cycle.
- FIFO:
  - Write and read pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop leaves the count unchanged, including at full-1 and empty+1 boundaries.
  - Pop on empty is impossible (out_valid=0).
  - The head is driven combinationally from storage.
- err_count increments by 1 on each stage-1 load with a flag set. It saturates at 255 and never wraps.
- out_valid/out_diff/flags are stable while out_valid & !out_ready (standard valid/ready rule).
- Reset mid-stream: all in-flight and buffered entries are discarded; no output after release until new input.

Optional Feature:
- Macro: PERIPHERAL_SUBTRACTOR_SATURATE_EN.
- Defined: on underflow out_diff=0; on overflow out_diff=2^DATA_WIDTH-1. Flags and err_count are unchanged.
- Undefined: out_diff is the wrapped low DATA_WIDTH bits.

Decomposition:
- Package peripheral_subtractor_pkg:
  - Default-width constants.
  - Packed struct result_t {diff, underflow, overflow}, stored whole in the FIFO.
- One natural sub-module: peripheral_subtractor_fifo.
  - Parameterised on depth and entry width.
  - Handles push/pop, count, and pointer wrap.

Test Plan:
- Basic (DATA_WIDTH=8): in_sum=300, in_operand=45, out_ready=1 -> after 2 edges out_diff=255, no flags; err_count=0.
- Underflow: in_sum=10, in_operand=20 -> underflow=1, overflow=0, err_count=1.
  - Wrap build: out_diff=246.
  - SATURATE_EN build: out_diff=0.
- Overflow: in_sum=511, in_operand=0 -> overflow=1.
  - Wrap build: out_diff=255.
  - SATURATE_EN build: out_diff=255.
  - in_sum=400, in_operand=100 -> overflow=1; wrap 44, saturate 255.
- Backpressure: hold out_ready=0 and stream inputs sum=k+100, op=k for k=0.. -> exactly 4 beats accepted.
  - in_ready=0 once occupancy is 4.
  - Release out_ready -> 4 results of 100 emitted in order; head stable while stalled.
- Full streaming: continuous in_valid/out_ready for 16 beats of random values -> one result per cycle, no bubbles, order preserved.
  - Simultaneous push and pop keeps the count constant.
- Error saturation and reset: 300 underflowing beats -> err_count=255.
  - Assert rst=0 with 2 entries buffered -> out_valid=0, err_count=0, in_ready=0 immediately.
  - After release, a fresh beat 5-3 -> out_diff=2.
